// File: rtl/key_conditioner_if.sv
// Front-panel key bus: raw active-low buttons in, debounced level and
// single-cycle press pulses out. master = key source/consumer, slave = conditioner.
interface key_conditioner_if #(
    parameter int NKEYS = 4
);
    logic [NKEYS-1:0] key_n;
    logic [NKEYS-1:0] press;
    logic [NKEYS-1:0] level;

    modport master (output key_n, input press, input level);
    modport slave  (input key_n, output press, output level);
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchronizer, debouncer and press-pulse generator with optional auto-repeat.
// Auto-repeat (DELAY/RATE states, rcnt) is compiled in only when KEY_AUTOREPEAT_EN is defined.
module key_conditioner_lane #(
    parameter int DEBOUNCE_CYC     = 500000,
    parameter int REPEAT_DELAY_CYC = 25000000,
    parameter int REPEAT_RATE_CYC  = 5000000,
    parameter bit REPEAT_EN        = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press,
    output logic level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC);

    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the synced input disagrees with the accepted level,
    // so any shorter mismatch run is forgotten on the first agreeing edge.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= ~key_n;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX   = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_RATE} state_t;

    state_t            state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;

    // A falling level wins over a terminal count on the same edge: no pulse.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        press_d = 1'b0;
        if (!level_d) begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!level_q) begin
                        press_d = 1'b1;
                        rcnt_d  = '0;
                        state_d = REPEAT_EN ? ST_DELAY : ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    if (rcnt_q == RCNT_W'(REPEAT_DELAY_CYC - 1)) begin
                        press_d = 1'b1;
                        rcnt_d  = '0;
                        state_d = ST_RATE;
                    end else begin
                        rcnt_d = rcnt_q + RCNT_W'(1);
                    end
                end
                ST_RATE: begin
                    if (rcnt_q == RCNT_W'(REPEAT_RATE_CYC - 1)) begin
                        press_d = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + RCNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_EN, REPEAT_DELAY_CYC[0], REPEAT_RATE_CYC[0]};

    always_comb begin
        press_d = level_d & ~level_q;
    end
`endif

    assign press = press_q;
    assign level = level_q;
endmodule

module key_conditioner #(
    parameter int               NKEYS            = 4,
    parameter int               DEBOUNCE_CYC     = 500000,
    parameter int               REPEAT_DELAY_CYC = 25000000,
    parameter int               REPEAT_RATE_CYC  = 5000000,
    parameter logic [NKEYS-1:0] REPEAT_MASK      = 4'b0110
) (
    input  logic               clk,
    input  logic               reset,
    key_conditioner_if.slave   kif
);
    logic [NKEYS-1:0] press_w;
    logic [NKEYS-1:0] level_w;

    for (genvar i = 0; i < NKEYS; i++) begin : g_lane
        key_conditioner_lane #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC),
            .REPEAT_EN        (REPEAT_MASK[i])
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .key_n (kif.key_n[i]),
            .press (press_w[i]),
            .level (level_w[i])
        );
    end

    assign kif.press = press_w;
    assign kif.level = level_w;
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: window-based debounce/repeat model checked every cycle,
// plus literal pulse/level edge lists for each directed scenario.
module tb_key_conditioner;
    localparam int         NK   = 4;
    localparam int         DEB  = 4;
    localparam int         DLY  = 20;
    localparam int         RATE = 8;
    localparam logic [3:0] MASK = 4'b0110;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    key_conditioner_if #(.NKEYS(NK)) kif ();

    key_conditioner #(
        .NKEYS(NK), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY_CYC(DLY),
        .REPEAT_RATE_CYC(RATE), .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk), .reset(reset), .kif(kif)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Edge bookkeeping: edge_n is the number of the most recent rising edge.
    int         edge_n = 0;
    logic       rst_s  = 1'b0;
    logic [3:0] key_s  = '0;
    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        rst_s  <= reset;
        key_s  <= ~kif.key_n;
    end

    // Model state: sample history by edge, level per key, last change and last rise edges.
    logic [3:0] hist [0:4095];
    logic [3:0] lvl_m = '0;
    int         last_chg [NK];
    int         rise_m   [NK];
    bit         started = 1'b0;

    // Event log of DUT outputs for the literal checks.
    int pe [NK][32];
    int pn [NK];
    int rn [NK];
    int rise_e [NK];
    int fall_e [NK];
    logic [3:0] lvl_prev = '0;

    always @(negedge clk) begin
        int t, d;
        bit flip;
        logic [3:0] ep;
        t  = edge_n;
        ep = '0;
        if (rst_s) begin
            started = 1'b1;
            hist[t] = '0;
            if (t > 0) hist[t-1] = '0;
            lvl_m = '0;
            for (int k = 0; k < NK; k++) begin
                last_chg[k] = t;
                rise_m[k]   = -100000;
            end
        end else if (started) begin
            hist[t] = key_s;
            for (int k = 0; k < NK; k++) begin
                // Level flips once DEB consecutive synced samples since the last change disagree.
                flip = (t - last_chg[k] >= DEB);
                for (int j = t - DEB - 1; j <= t - 2; j++)
                    if (j < 0 || hist[j][k] == lvl_m[k]) flip = 1'b0;
                if (flip) begin
                    lvl_m[k]    = ~lvl_m[k];
                    last_chg[k] = t;
                    if (lvl_m[k]) begin
                        rise_m[k] = t;
                        ep[k]     = 1'b1;
                    end
                end else if (lvl_m[k] && REP_ON && MASK[k]) begin
                    d = t - rise_m[k];
                    if (d == DLY || (d > DLY && (d - DLY) % RATE == 0)) ep[k] = 1'b1;
                end
            end
        end
        if (started) begin
            chk($sformatf("level@%0d", t), int'(kif.level), int'(lvl_m));
            chk($sformatf("press@%0d", t), int'(kif.press), int'(ep));
            for (int k = 0; k < NK; k++) begin
                if (kif.press[k] === 1'b1 && pn[k] < 32) begin
                    pe[k][pn[k]] = t;
                    pn[k]++;
                end
                if (kif.level[k] === 1'b1 && !lvl_prev[k]) begin
                    rise_e[k] = t;
                    rn[k]++;
                end
                if (kif.level[k] === 1'b0 && lvl_prev[k]) fall_e[k] = t;
            end
            lvl_prev = kif.level;
        end
    end

    task automatic clear_log();
        for (int k = 0; k < NK; k++) begin
            pn[k] = 0; rn[k] = 0; rise_e[k] = -1; fall_e[k] = -1;
            for (int i = 0; i < 32; i++) pe[k][i] = -1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_pulses(input string nm, input int k, input int e[32], input int n);
        chk($sformatf("%s count", nm), pn[k], n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s pulse%0d", nm, i), pe[k][i], e[i]);
    endtask

    initial begin
        int e0, p, n;
        int e [32];
        kif.key_n = '1;
        reset     = 1'b1;
        clear_log();
        step(3);
        chk("reset press", int'(kif.press), 0);
        chk("reset level", int'(kif.level), 0);
        reset = 1'b0;
        step(5);

        // Clean press on key 0 (no repeat), low for 100 samples.
        clear_log();
        e0 = edge_n + 1;
        kif.key_n[0] = 1'b0;
        step(100);
        kif.key_n[0] = 1'b1;
        step(15);
        e[0] = e0 + 5;
        chk_pulses("k0", 0, e, 1);
        chk("k0 rise", rise_e[0], e0 + 5);
        chk("k0 fall", fall_e[0], e0 + 105);
        chk("k0 others", pn[1] + pn[2] + pn[3], 0);

        // Glitch on key 1: three low samples are one short of the debounce run.
        clear_log();
        kif.key_n[1] = 1'b0;
        step(3);
        kif.key_n[1] = 1'b1;
        step(10);
        chk("glitch press", pn[1], 0);
        chk("glitch level", rn[1], 0);

        // Held add key 2; level falls exactly when the P+60 repeat would fire.
        clear_log();
        e0 = edge_n + 1;
        p  = e0 + 5;
        kif.key_n[2] = 1'b0;
        step(60);
        kif.key_n[2] = 1'b1;
        step(20);
        e[0] = p; e[1] = p + 20; e[2] = p + 28; e[3] = p + 36; e[4] = p + 44; e[5] = p + 52;
        n = REP_ON ? 6 : 1;
        chk_pulses("k2 hold", 2, e, n);
        chk("k2 fall", fall_e[2], p + 60);

        // Simultaneous keys 1 and 2.
        clear_log();
        e0 = edge_n + 1;
        kif.key_n[1] = 1'b0;
        kif.key_n[2] = 1'b0;
        step(10);
        kif.key_n[1] = 1'b1;
        kif.key_n[2] = 1'b1;
        step(15);
        e[0] = e0 + 5;
        chk_pulses("sim k1", 1, e, 1);
        chk_pulses("sim k2", 2, e, 1);

        // Reset while key 2 repeats, key held through deassertion.
        clear_log();
        e0 = edge_n + 1;
        p  = e0 + 5;
        kif.key_n[2] = 1'b0;
        step(35);
        reset = 1'b1;
        step(1);
        chk("mid reset press", int'(kif.press), 0);
        chk("mid reset level", int'(kif.level), 0);
        step(1);
        reset = 1'b0;
        step(33);
        kif.key_n[2] = 1'b1;
        step(20);
        e[0] = p;
        e[1] = REP_ON ? p + 20 : p + 37;
        e[2] = p + 28; e[3] = p + 37; e[4] = p + 57; e[5] = p + 65;
        n = REP_ON ? 6 : 2;
        chk_pulses("k2 reset", 2, e, n);
        chk("k2 rerise", rise_e[2], p + 37);

        // Long hold on keys 0 (masked) and 2: 24 pulses with repeat, one without.
        clear_log();
        e0 = edge_n + 1;
        p  = e0 + 5;
        kif.key_n[0] = 1'b0;
        kif.key_n[2] = 1'b0;
        step(200);
        kif.key_n[0] = 1'b1;
        kif.key_n[2] = 1'b1;
        step(15);
        e[0] = p;
        for (int i = 1; i < 24; i++) e[i] = p + DLY + (i - 1) * RATE;
        n = REP_ON ? 24 : 1;
        chk_pulses("k2 long", 2, e, n);
        e[0] = p;
        chk_pulses("k0 long", 0, e, 1);
        chk("k2 long fall", fall_e[2], p + 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
